// File: rtl/led_cmd_parser.sv
// LED panel command parser: buffers UART bytes in a small FIFO, decodes panel opcodes and
// presents one frame-buffer write at a time over a valid/ready handshake.
module led_cmd_parser #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] rx_data,
  input  logic       rx_dv,
  input  logic       fb_ready,
  input  logic       ovf_clr,
  output logic       fb_we,
  output logic [1:0] fb_op,
  output logic [3:0] fb_col,
  output logic [3:0] fb_row,
  output logic [2:0] rgb,
  output logic       overflow,
  output logic       cmd_err,
  output logic       busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ARG  = 1'b1
  } state_t;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [15:0]   tmo_q, tmo_d;
  logic          fb_we_q, fb_we_d;
  logic [1:0]    fb_op_q, fb_op_d;
  logic [3:0]    fb_col_q, fb_col_d;
  logic [3:0]    fb_row_q, fb_row_d;
  logic [2:0]    rgb_q, rgb_d;
  logic          cmd_err_q, cmd_err_d;

  logic       fifo_empty, fifo_full;
  logic       pop, push, drop;
  logic [7:0] byte_out;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(DEPTH));
  // A stalled write blocks decoding so its fields stay stable until accepted.
  assign pop        = !fifo_empty && (!fb_we_q || fb_ready);
  assign push       = rx_dv && (!fifo_full || pop);
  assign drop       = rx_dv && fifo_full && !pop;
  assign byte_out   = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= rx_data;
    end
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    tmo_d     = tmo_q;
    fb_we_d   = fb_we_q;
    fb_op_d   = fb_op_q;
    fb_col_d  = fb_col_q;
    fb_row_d  = fb_row_q;
    rgb_d     = rgb_q;
    cmd_err_d = 1'b0;

    if (fb_we_q && fb_ready) begin
      fb_we_d = 1'b0;
    end

    if (pop) begin
      case (state_q)
        ST_IDLE: begin
          case (byte_out[7:4])
            4'h0: rgb_d = byte_out[2:0];
            4'h1: begin
              state_d = ST_ARG;
              op_d    = 2'b01;
              tmo_d   = '0;
            end
            4'h2: begin
              state_d = ST_ARG;
              op_d    = 2'b10;
              tmo_d   = '0;
            end
            4'h3: begin
              fb_we_d  = 1'b1;
              fb_op_d  = 2'b11;
              fb_col_d = 4'h0;
              fb_row_d = 4'h0;
            end
            4'hF: begin
              state_d = ST_IDLE;
            end
            default: cmd_err_d = 1'b1;
          endcase
        end
        default: begin
          // Any byte is accepted as the argument, including 0xFx.
          fb_we_d  = 1'b1;
          fb_op_d  = op_q;
          fb_col_d = byte_out[7:4];
          fb_row_d = byte_out[3:0];
          state_d  = ST_IDLE;
        end
      endcase
    end else if (state_q == ST_ARG) begin
      if (tmo_q == TMO_LAST) begin
        state_d   = ST_IDLE;
        cmd_err_d = 1'b1;
        tmo_d     = '0;
      end else begin
        tmo_d = tmo_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= ST_IDLE;
      op_q       <= 2'b00;
      tmo_q      <= '0;
      fb_we_q    <= 1'b0;
      fb_op_q    <= 2'b00;
      fb_col_q   <= 4'h0;
      fb_row_q   <= 4'h0;
      rgb_q      <= 3'b011;
      cmd_err_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      op_q       <= op_d;
      tmo_q      <= tmo_d;
      fb_we_q    <= fb_we_d;
      fb_op_q    <= fb_op_d;
      fb_col_q   <= fb_col_d;
      fb_row_q   <= fb_row_d;
      rgb_q      <= rgb_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  assign fb_we    = fb_we_q;
  assign fb_op    = fb_op_q;
  assign fb_col   = fb_col_q;
  assign fb_row   = fb_row_q;
  assign rgb      = rgb_q;
  assign overflow = overflow_q;
  assign cmd_err  = cmd_err_q;
  assign busy     = !fifo_empty || (state_q != ST_IDLE) || fb_we_q;

endmodule

// File: tb/tb_led_cmd_parser.sv
// Self-checking bench for led_cmd_parser: a table of single commands plus hand-written
// sequences for reset, stall, overflow and timeout; writes are checked through a scoreboard.
module tb_led_cmd_parser;

  localparam int DEPTH = 4;
  localparam int TMO   = 20;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_dv = 1'b0;
  logic       fb_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       fb_we;
  logic [1:0] fb_op;
  logic [3:0] fb_col;
  logic [3:0] fb_row;
  logic [2:0] rgb;
  logic       overflow;
  logic       cmd_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int xfers = 0;
  int errs_seen = 0;
  logic [9:0] exp_q[$];

  led_cmd_parser #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_dv(rx_dv),
    .fb_ready(fb_ready), .ovf_clr(ovf_clr), .fb_we(fb_we), .fb_op(fb_op),
    .fb_col(fb_col), .fb_row(fb_row), .rgb(rgb), .overflow(overflow),
    .cmd_err(cmd_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_dv   = 1'b1;
    tick();
    rx_dv   = 1'b0;
  endtask

  task automatic expect_wr(input logic [1:0] op, input logic [3:0] col, input logic [3:0] row);
    exp_q.push_back({op, col, row});
  endtask

  // Scoreboard: every accepted write must match the oldest expected write.
  always @(negedge clk) begin
    if (reset_n && fb_we && fb_ready) begin
      xfers++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL xfer_unexpected: got op=%0b col=%0h row=%0h, expected none", fb_op, fb_col, fb_row);
      end else begin
        chk("xfer", {22'd0, fb_op, fb_col, fb_row}, {22'd0, exp_q.pop_front()});
      end
    end
    if (reset_n && cmd_err) errs_seen++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    int         nbytes;
    logic       we;
    logic [1:0] op;
    logic [3:0] col;
    logic [3:0] row;
    logic [2:0] rgb;
    int         errs;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int err0;
    int xf0;
    int run;

    vecs[0] = '{8'h06, 8'h00, 1, 1'b0, 2'b00, 4'h0, 4'h0, 3'b110, 0};
    vecs[1] = '{8'h77, 8'h00, 1, 1'b0, 2'b00, 4'h0, 4'h0, 3'b110, 1};
    vecs[2] = '{8'hF0, 8'h00, 1, 1'b0, 2'b00, 4'h0, 4'h0, 3'b110, 0};
    vecs[3] = '{8'h10, 8'hF3, 2, 1'b1, 2'b01, 4'hF, 4'h3, 3'b110, 0};
    vecs[4] = '{8'h2C, 8'h9E, 2, 1'b1, 2'b10, 4'h9, 4'hE, 3'b110, 0};
    vecs[5] = '{8'h31, 8'h00, 1, 1'b1, 2'b11, 4'h0, 4'h0, 3'b110, 0};
    vecs[6] = '{8'h00, 8'h00, 1, 1'b0, 2'b00, 4'h0, 4'h0, 3'b000, 0};
    vecs[7] = '{8'hE1, 8'h00, 1, 1'b0, 2'b00, 4'h0, 4'h0, 3'b000, 1};
    vecs[8] = '{8'h20, 8'hF0, 2, 1'b1, 2'b10, 4'hF, 4'h0, 3'b000, 0};
    vecs[9] = '{8'h4A, 8'h00, 1, 1'b0, 2'b00, 4'h0, 4'h0, 3'b000, 1};

    // Reset values and mid-command reset
    fb_ready = 1'b1;
    repeat (3) tick();
    chk("rst_rgb", 32'(rgb), 32'(3'b011));
    chk("rst_fb_we", 32'(fb_we), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    tick();
    send(8'h10);
    tick();
    chk("arg_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #2;
    chk("async_rst_busy", 32'(busy), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    send(8'h35);
    expect_wr(2'b11, 4'h0, 4'h0);
    tick();
    chk("post_rst_op", 32'({fb_we, fb_op, fb_col, fb_row}), 32'({1'b1, 2'b11, 8'h00}));
    repeat (2) tick();
    chk("post_rst_drain", 32'(exp_q.size()), 32'd0);

    // Set pixel latency: fb_we rises two clocks after the argument strobe
    send(8'h10);
    send(8'hA5);
    expect_wr(2'b01, 4'hA, 4'h5);
    chk("lat_we_early", 32'(fb_we), 32'd0);
    tick();
    chk("lat_we_fields", 32'({fb_we, fb_op, fb_col, fb_row}), 32'({1'b1, 2'b01, 4'hA, 4'h5}));
    tick();
    chk("lat_we_pulse", 32'(fb_we), 32'd0);

    // Table of single commands
    for (int i = 0; i < 10; i++) begin
      err0 = errs_seen;
      send(vecs[i].b0);
      if (vecs[i].nbytes == 2) send(vecs[i].b1);
      if (vecs[i].we) expect_wr(vecs[i].op, vecs[i].col, vecs[i].row);
      repeat (4) tick();
      chk($sformatf("vec%0d_rgb", i), 32'(rgb), 32'(vecs[i].rgb));
      chk($sformatf("vec%0d_err", i), 32'(errs_seen - err0), 32'(vecs[i].errs));
      chk($sformatf("vec%0d_wr_done", i), 32'(exp_q.size()), 32'd0);
      chk($sformatf("vec%0d_idle", i), 32'(busy), 32'd0);
    end

    // Stalled write holds its fields; colour update goes ahead
    fb_ready = 1'b0;
    send(8'h05);
    send(8'h23);
    send(8'h47);
    expect_wr(2'b10, 4'h4, 4'h7);
    tick();
    chk("stall_rgb", 32'(rgb), 32'(3'b101));
    for (int i = 0; i < 10; i++) begin
      chk("stall_hold", 32'({fb_we, fb_op, fb_col, fb_row}), 32'({1'b1, 2'b10, 4'h4, 4'h7}));
      tick();
    end
    xf0 = xfers;
    fb_ready = 1'b1;
    repeat (2) tick();
    fb_ready = 1'b0;
    tick();
    chk("stall_one_xfer", 32'(xfers - xf0), 32'd1);
    chk("stall_we_low", 32'(fb_we), 32'd0);

    // Overflow with a full FIFO, then back-to-back clear-screen transfers
    for (int i = 0; i < 6; i++) send(8'h30);
    for (int i = 0; i < 5; i++) expect_wr(2'b11, 4'h0, 4'h0);
    chk("ovf_set", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);
    ovf_clr = 1'b1;
    rx_data = 8'h30;
    rx_dv = 1'b1;
    tick();
    ovf_clr = 1'b0;
    rx_dv = 1'b0;
    chk("ovf_clr_vs_drop", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr2", 32'(overflow), 32'd0);
    xf0 = xfers;
    fb_ready = 1'b1;
    run = 0;
    while (fb_we === 1'b1 && run < 20) begin
      run++;
      tick();
    end
    chk("b2b_run_len", 32'(run), 32'd5);
    chk("b2b_xfers", 32'(xfers - xf0), 32'd5);
    repeat (2) tick();
    chk("b2b_drain", 32'(exp_q.size()), 32'd0);

    // Argument timeout
    err0 = errs_seen;
    send(8'h10);
    repeat (TMO) tick();
    chk("tmo_not_yet", 32'(cmd_err), 32'd0);
    chk("tmo_busy", 32'(busy), 32'd1);
    tick();
    chk("tmo_err", 32'(cmd_err), 32'd1);
    chk("tmo_idle", 32'(busy), 32'd0);
    tick();
    chk("tmo_err_pulse", 32'(cmd_err), 32'd0);
    chk("tmo_err_count", 32'(errs_seen - err0), 32'd1);
    send(8'h02);
    tick();
    chk("tmo_then_rgb", 32'(rgb), 32'(3'b010));
    repeat (2) tick();
    chk("final_no_pending", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
